// File: rtl/candy_regs_wb_pkg.sv
// Shared register-file constants for the candy writeback buffer.
// Optional forwarding is enabled by defining CANDY_WB_BYPASS_EN.
package candy_regs_wb_pkg;

  localparam int REG_BUS_W  = 24;   // RegBus
  localparam int REG_ADDR_W = 4;    // RegAddrBus
  localparam int WB_DEPTH   = 4;    // WbDepth

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  function automatic int wb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/candy_wb_fifo.sv
// Writeback FIFO: storage, wrapping pointers and occupancy count.
// The entry array is exported so the top level can search pending writes.
module candy_wb_fifo
  import candy_regs_wb_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = WB_DEPTH,
  localparam int PTR_W = wb_ptr_w(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              push_addr,
  input  logic [DATA_W-1:0]              push_data,
  output logic [ADDR_W-1:0]              head_addr,
  output logic [DATA_W-1:0]              head_data,
  output logic [PTR_W-1:0]               rd_ptr,
  output logic [CNT_W-1:0]               count,
  output logic                           full,
  output logic                           empty,
  output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]   ent_data
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: stale slots are never visible because count gates them.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
        addr_d = push_addr;
        data_d = push_data;
      end
    end

    always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
    end

    assign ent_addr[gi] = addr_q;
    assign ent_data[gi] = data_q;
  end

  assign head_addr = ent_addr[rd_ptr_q];
  assign head_data = ent_data[rd_ptr_q];
  assign rd_ptr    = rd_ptr_q;
  assign count     = count_q;

endmodule

// File: rtl/candy_regs_wb.sv
// Writeback buffer in front of the candy_regs write port: handshake, r0 filter, drain.
// Define CANDY_WB_BYPASS_EN to compile in the youngest-match forwarding search.
module candy_regs_wb
  import candy_regs_wb_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wport_busy,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              empty
);

  localparam int PTR_W = wb_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                         push;
  logic                         full;
  logic                         fifo_empty;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             count;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;

  // A full buffer refuses input even when the head drains this cycle.
  assign in_ready = (rst != RST_ENABLE) && !full;
  assign push     = in_valid && in_ready && (in_addr != '0);

  assign we    = !fifo_empty && !wport_busy;
  assign waddr = fifo_empty ? '0 : head_addr;
  assign wdata = fifo_empty ? '0 : head_data;
  assign empty = fifo_empty;

  candy_wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (we),
    .push_addr (in_addr),
    .push_data (in_data),
    .head_addr (head_addr),
    .head_data (head_data),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .full      (full),
    .empty     (fifo_empty),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

`ifdef CANDY_WB_BYPASS_EN
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match (the youngest) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((fwd_addr != '0) && (CNT_W'(k) < count) && (ent_addr[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end
`else
  logic unused_bypass;

  assign fwd_hit       = 1'b0;
  assign fwd_data      = '0;
  assign unused_bypass = ^{fwd_addr, rd_ptr, count, ent_addr, ent_data};
`endif

endmodule

// File: tb/tb_candy_regs_wb.sv
// Scoreboard bench for candy_regs_wb: directed scenarios followed by random traffic.
// Forwarding expectations follow CANDY_WB_BYPASS_EN.
module tb_candy_regs_wb;

  localparam int DW = 24;
  localparam int AW = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          wport_busy = 1'b0;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] fwd_addr = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          empty;

  int   errors = 0;
  int   checks = 0;
  ent_t exp_q[$];
  bit   random_mode = 1'b0;

  candy_regs_wb dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .wport_busy (wport_busy),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .fwd_addr   (fwd_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every cycle against the queued model, pops on each expected write.
  always @(negedge clk) begin
    int            n;
    logic          exp_we;
    logic          exp_hit;
    logic [DW-1:0] exp_fdata;
    if (rst) begin
      exp_q.delete();
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_waddr", 32'(waddr), 32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
      chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
      chk("rst_fwd_data", 32'(fwd_data), 32'd0);
    end else begin
      n      = exp_q.size();
      exp_we = (n != 0) && !wport_busy;
      chk("we", 32'(we), 32'(exp_we));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
      chk("waddr", 32'(waddr), (n != 0) ? 32'(exp_q[0].a) : 32'd0);
      chk("wdata", 32'(wdata), (n != 0) ? 32'(exp_q[0].d) : 32'd0);
      exp_hit   = 1'b0;
      exp_fdata = '0;
`ifdef CANDY_WB_BYPASS_EN
      if (fwd_addr != '0) begin
        foreach (exp_q[i]) begin
          if (exp_q[i].a == fwd_addr) begin
            exp_hit   = 1'b1;
            exp_fdata = exp_q[i].d;
          end
        end
      end
`endif
      chk("fwd_hit", 32'(fwd_hit), 32'(exp_hit));
      chk("fwd_data", 32'(fwd_data), 32'(exp_fdata));
      if (exp_we) begin
        $display("write r%0d = %h at %0t", waddr, wdata, $time);
        void'(exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (random_mode) begin
      #1 wport_busy = ($urandom_range(0, 9) < 3);
    end
  end

  // Presents one result and waits for the handshake; the expected write is queued at that edge.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clk);
    if (accepted && (a != '0)) exp_q.push_back('{a: a, d: d});
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL send_timeout: got in_ready 0 required 1 for r%0d", a);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    bit seen;
    seen = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (empty) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(1);

    // Basic write
    send(4'd1, 24'h124b36);
    wait_empty("basic_drain");

    // Back-to-back pushes
    send(4'd1, 24'h124b36);
    send(4'd2, 24'h655356);
    send(4'd3, 24'h5a0024);
    send(4'd4, 24'h5a0034);
    wait_empty("b2b_drain");

    // Full buffer under a busy write port
    wport_busy = 1'b1;
    for (int i = 1; i <= DEPTH; i++) send(AW'(i), DW'(32'h00a000 + i));
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_we", 32'(we), 32'd0);
    fork
      send(4'd5, 24'h00a005);
      begin
        idle(3);
        wport_busy = 1'b0;
      end
    join
    wait_empty("full_drain");
    @(negedge clk);
    chk("after_full_in_ready", 32'(in_ready), 32'd1);
    idle(1);

    // Forwarding: youngest of two pending writes to r3
    wport_busy = 1'b1;
    send(4'd3, 24'h000001);
    send(4'd3, 24'h000002);
    fwd_addr = 4'd3;
    @(negedge clk);
`ifdef CANDY_WB_BYPASS_EN
    chk("fwd3_hit", 32'(fwd_hit), 32'd1);
    chk("fwd3_data", 32'(fwd_data), 32'h000002);
`else
    chk("fwd3_hit", 32'(fwd_hit), 32'd0);
    chk("fwd3_data", 32'(fwd_data), 32'd0);
`endif
    @(posedge clk);
    #1 fwd_addr = 4'd5;
    @(negedge clk);
    chk("fwd5_hit", 32'(fwd_hit), 32'd0);
    @(posedge clk);
    #1 wport_busy = 1'b0;
    fwd_addr = 4'd0;
    wait_empty("fwd_drain");

    // r0 writes are accepted and dropped
    send(4'd0, 24'hffffff);
    @(negedge clk);
    chk("r0_empty", 32'(empty), 32'd1);
    chk("r0_we", 32'(we), 32'd0);
    idle(1);

    // Reset mid-drain discards pending entries
    wport_busy = 1'b1;
    send(4'd7, 24'h070707);
    send(4'd8, 24'h080808);
    send(4'd9, 24'h090909);
    rst = 1'b1;
    #20;
    rst = 1'b0;
    wport_busy = 1'b0;
    @(negedge clk);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_we", 32'(we), 32'd0);
    idle(5);

    // Random traffic
    random_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      fwd_addr = AW'($urandom);
      if ($urandom_range(0, 3) != 0) send(AW'($urandom), DW'($urandom));
      else idle(1);
    end
    random_mode = 1'b0;
    @(posedge clk);
    #1 wport_busy = 1'b0;
    wait_empty("final_drain");
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
